hack_vga_scanout: RTL
=====================

HACK_VGA_SCANOUT -- requirements
Module: hack_vga_scanout

Interface
REQ-001 SHALL have parameters, one per line:
- BORDER_RGB, default 12'h008, border colour outside the Hack window.
- FG_RGB, default 12'h000, colour for pixel bit 1.
- BG_RGB, default 12'hFFF, colour for pixel bit 0.
REQ-002 SHALL have ports, one per line:
- clk  input  1  pixel clock, 25.175 MHz nominal, one pixel per cycle.
- rst  input  1  synchronous active-high reset.
- vram_addr  output  13  screen-RAM word address, driven to the read port of the dual-port RAM.
- vram_rdata  input  16  RAM read data, valid one clk after vram_addr.
- vga_hsync  output  1  horizontal sync, active-low.
- vga_vsync  output  1  vertical sync, active-low.
- vga_r, vga_g, vga_b  output  4 each  colour.
- frame_start  output  1  one-cycle pulse at the first blanking line after the active video.
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 Counters: h_cnt 0..799, v_cnt 0..524; h_cnt wraps 799->0 and increments v_cnt; v_cnt wraps 524->0.
REQ-005 Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-006 Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-007 Hack window: 512x256, VGA columns 64..575, rows 112..367; window coords c=h-64, r=v-112.
REQ-008 Window pixel (c,r) SHALL show bit (c mod 16) of word r*32 + c/16; bit 1 -> FG_RGB, bit 0 -> BG_RGB.
REQ-009 Active area outside the window -> border colour per REQ-016; blanking -> RGB 0.
REQ-010 Fetch: each 16-pixel word SHALL be addressed early enough that, with the 1-cycle RAM latency, its data is loaded into a 16-bit shift register exactly at its first pixel; no pixel is skipped or repeated across word boundaries.
REQ-011 Fixed pipeline latency: sync, RGB and frame_start SHALL all lag the counters by exactly 2 clk, so sync and colour stay mutually aligned.
REQ-012 vram_addr SHALL stay in 0..8191 at all times and hold its last value outside fetch windows.
REQ-013 frame_start SHALL pulse exactly once per frame, when v_cnt=480 and h_cnt=0, delayed per REQ-011.

Reset
REQ-014 While rst=1: h_cnt=v_cnt=0, shift register=0, vram_addr=0, vga_hsync=vga_vsync=1, RGB=0, frame_start=0.
REQ-015 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL start at h_cnt=0, v_cnt=0, with the first valid output 2 clk later.

Configuration
REQ-016 HACK_VGA_BORDER_EN defined: the border area shows BORDER_RGB. Undefined: the border shows RGB 0, and BORDER_RGB is unused.

Structure
REQ-017 hack_vga_pkg SHALL hold the timing constants (H/V active, porches, sync, totals), the window offsets (64, 112) and the Hack screen dimensions (512, 256, 32 words/row).
REQ-018 Sub-module vga_timing SHALL hold the counters and raw sync/active generation; hack_vga_scanout SHALL hold fetch, shift and colour.

Verification
REQ-019 Reset release, run 1 frame -> hsync low for 96 clk every 800; vsync low for exactly 1600 clk; frame period 420000 clk.
REQ-020 RAM word 0 = 16'h0001, rest 0 -> only VGA pixel (64,112) FG; (65,112) BG; (63,112) border.
REQ-021 Word 31 = 16'h8000, word 8191 = 16'h8000 -> FG at (575,112) and (575,367); (576,*) border.
REQ-022 Word 1 = 16'hFFFF, word 0 = 0 -> columns 80..95 of row 112 FG, 79 and 96 BG; checks word-boundary alignment.
REQ-023 Assert rst at h_cnt=300, v_cnt=200 for 3 clk -> outputs at reset values; after release the next hsync falls exactly 658 clk later.
REQ-024 Build with and without HACK_VGA_BORDER_EN -> pixel (10,10) = BORDER_RGB or 0 respectively; frame_start once per 420000 clk.

Source files
------------

// File: rtl/hack_vga_pkg.sv
// Shared timing constants, Hack window geometry and pipeline types for the Hack VGA scanout.
package hack_vga_pkg;

    localparam int unsigned CntW  = 10;
    localparam int unsigned AddrW = 13;

    typedef logic [CntW-1:0]  cnt_t;
    typedef logic [AddrW-1:0] addr_t;

    // 640x480 @ 60 Hz horizontal timing
    localparam cnt_t HActive    = 10'd640;
    localparam cnt_t HFp        = 10'd16;
    localparam cnt_t HSync      = 10'd96;
    localparam cnt_t HBp        = 10'd48;
    localparam cnt_t HSyncStart = HActive + HFp;
    localparam cnt_t HSyncEnd   = HSyncStart + HSync;
    localparam cnt_t HTotal     = HSyncEnd + HBp;

    localparam cnt_t VActive    = 10'd480;
    localparam cnt_t VFp        = 10'd10;
    localparam cnt_t VSync      = 10'd2;
    localparam cnt_t VBp        = 10'd33;
    localparam cnt_t VSyncStart = VActive + VFp;
    localparam cnt_t VSyncEnd   = VSyncStart + VSync;
    localparam cnt_t VTotal     = VSyncEnd + VBp;

    // Hack screen placed inside the active area
    localparam cnt_t  WinX0        = 10'd64;
    localparam cnt_t  WinY0        = 10'd112;
    localparam cnt_t  HackW        = 10'd512;
    localparam cnt_t  HackH        = 10'd256;
    localparam addr_t HackWordsRow = 13'd32;
    localparam cnt_t  WinX1        = WinX0 + HackW;
    localparam cnt_t  WinY1        = WinY0 + HackH;

    // Address goes out two counts ahead: one for the address register, one for RAM latency.
    localparam cnt_t FetchLead = 10'd2;
    localparam cnt_t FetchX0   = WinX0 - FetchLead;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
        logic in_win;
        logic frame;
    } vid_ctl_t;

    function automatic addr_t word_addr(input cnt_t row, input cnt_t word_col);
        return addr_t'(row) * HackWordsRow + addr_t'(word_col);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 pixel/line counters with raw (unregistered) sync, active and frame tick.
module vga_timing
    import hack_vga_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic [CntW-1:0] h_cnt,
    output logic [CntW-1:0] v_cnt,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            active,
    output logic            frame_tick
);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HTotal - 10'd1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VTotal - 10'd1) ? '0 : v_cnt_q + 10'd1;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign hsync_n    = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
    assign vsync_n    = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));
    assign active     = (h_cnt_q < HActive) && (v_cnt_q < VActive);
    assign frame_tick = (v_cnt_q == VActive) && (h_cnt_q == '0);

endmodule

// File: rtl/hack_vga_scanout.sv
// Hack 512x256 monochrome screen scanout onto 640x480 VGA: word fetch, pixel shifter, colour.
// Define HACK_VGA_BORDER_EN to paint the area around the Hack window with BORDER_RGB.
module hack_vga_scanout
    import hack_vga_pkg::*;
#(
    parameter logic [11:0] BORDER_RGB = 12'h008,
    parameter logic [11:0] FG_RGB     = 12'h000,
    parameter logic [11:0] BG_RGB     = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [12:0] vram_addr,
    input  logic [15:0] vram_rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

`ifdef HACK_VGA_BORDER_EN
    localparam logic [11:0] BorderRgb = BORDER_RGB;
`else
    // Border disabled: forced to black.
    localparam logic [11:0] BorderRgb = BORDER_RGB & 12'h000;
`endif

    localparam vid_ctl_t CtlRst = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0,
                                    in_win: 1'b0, frame: 1'b0};

    logic [CntW-1:0] h_cnt, v_cnt;
    logic            hsync_n, vsync_n, active, frame_tick;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .active    (active),
        .frame_tick(frame_tick)
    );

    logic            win_row, win_col, fetch_en, load_en;
    cnt_t            row, fetch_col;
    logic [3:0]      pix_phase;
    vid_ctl_t        ctl_d, ctl_q;
    addr_t           vram_addr_q, vram_addr_d;
    logic [15:0]     shreg_q, shreg_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            hsync_q, vsync_q, frame_q;

    always_comb begin
        win_row   = (v_cnt >= WinY0) && (v_cnt < WinY1);
        win_col   = (h_cnt >= WinX0) && (h_cnt < WinX1);
        row       = v_cnt - WinY0;
        fetch_col = h_cnt - FetchX0;
        pix_phase = 4'(h_cnt - WinX0);

        fetch_en = win_row && (h_cnt >= FetchX0) && (h_cnt < WinX1 - FetchLead) &&
                   (fetch_col[3:0] == 4'd0);
        load_en  = win_row && win_col && (pix_phase == 4'd0);

        vram_addr_d = fetch_en ? word_addr(row, fetch_col >> 4) : vram_addr_q;
        // Bit 0 is always the pixel currently on its way out.
        shreg_d     = load_en ? vram_rdata : {1'b0, shreg_q[15:1]};

        ctl_d = '{hsync_n: hsync_n, vsync_n: vsync_n, active: active,
                  in_win: win_row && win_col, frame: frame_tick};
    end

    always_comb begin
        rgb_d = 12'h000;
        if (ctl_q.active) begin
            if (ctl_q.in_win) begin
                rgb_d = shreg_q[0] ? FG_RGB : BG_RGB;
            end else begin
                rgb_d = BorderRgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_addr_q <= '0;
            shreg_q     <= '0;
            ctl_q       <= CtlRst;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 12'h000;
            frame_q     <= 1'b0;
        end else begin
            vram_addr_q <= vram_addr_d;
            shreg_q     <= shreg_d;
            ctl_q       <= ctl_d;
            hsync_q     <= ctl_q.hsync_n;
            vsync_q     <= ctl_q.vsync_n;
            rgb_q       <= rgb_d;
            frame_q     <= ctl_q.frame;
        end
    end

    assign vram_addr   = vram_addr_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_q;

endmodule
